// File: rtl/entrada_step_ctrl.sv
// -----------------------------------------------------------------------------
// entrada_step_ctrl
// Execution sequencer between the board clock and the processor core. All
// logic runs on Clock. Instead of gating a slow system clock, the core sees a
// one-cycle Step_Enable pulse. The core is stalled while an input instruction
// waits. The push-button is synchronised and debounced. The switch value is
// latched on a confirmed press, and exactly one step is released per
// press/release cycle.
//
// Ports
//   Clock             board clock, rising-edge
//   Reset_n           synchronous reset, active-low
//   Esperar_Entrada   current instruction needs an input value
//   Confirma_Entrada  raw push-button (async, bouncy, active-high)
//   Entrada_lida      raw switches (async)
//   Step_Enable       one-cycle step pulse for PC / regfile / memories
//   Entrada_valida    switch value latched at confirm
//   LED_Wait          high while stalled waiting for input
//   Estado            FSM state: 0 RUN, 1 WAIT_PRESS, 2 WAIT_RELEASE, 3 COMMIT
// -----------------------------------------------------------------------------
module entrada_step_ctrl #(
  parameter int unsigned DIV_COUNT       = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned DATA_W          = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Esperar_Entrada,
  input  logic              Confirma_Entrada,
  input  logic [DATA_W-1:0] Entrada_lida,
  output logic              Step_Enable,
  output logic [DATA_W-1:0] Entrada_valida,
  output logic              LED_Wait,
  output logic [1:0]        Estado
);

  localparam int unsigned TICK_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_COUNT - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    COMMIT       = 2'd3
  } state_t;

  state_t              state;
  logic [TICK_W-1:0]   tick;

  logic                btn_meta;
  logic                btn_sync;
  logic                btn_deb;
  logic                btn_deb_prev;
  logic [DB_W-1:0]     db_cnt;
  logic [DATA_W-1:0]   data_meta;
  logic [DATA_W-1:0]   data_sync;
  logic                press;

  // Button and switch synchronisers plus button debouncer.
  // The debounced value follows the synced value only after they have
  // disagreed for DEBOUNCE_CYCLES consecutive cycles. Any agreement
  // restarts the count, so bounces never accumulate.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      btn_meta     <= 1'b0;
      btn_sync     <= 1'b0;
      btn_deb      <= 1'b0;
      btn_deb_prev <= 1'b0;
      db_cnt       <= '0;
      data_meta    <= '0;
      data_sync    <= '0;
    end else begin
      btn_meta     <= Confirma_Entrada;
      btn_sync     <= btn_meta;
      btn_deb_prev <= btn_deb;
      data_meta    <= Entrada_lida;
      data_sync    <= data_meta;
      if (btn_sync == btn_deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_deb <= btn_sync;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // A press is a rising edge of the debounced button. If the button is
  // already held when WAIT_PRESS is entered, there is no edge, so the
  // user must release the button and press it again.
  assign press = btn_deb & ~btn_deb_prev;

  // Sequencer FSM with registered outputs.
  // Step_Enable defaults low, so every pulse lasts exactly one cycle.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state          <= RUN;
      tick           <= '0;
      Step_Enable    <= 1'b0;
      Entrada_valida <= '0;
      LED_Wait       <= 1'b0;
    end else begin
      Step_Enable <= 1'b0;
      case (state)
        RUN: begin
          LED_Wait <= 1'b0;
          if (tick == TICK_LAST) begin
            tick <= '0;
            if (Esperar_Entrada) begin
              // Stall: the step for this tick is held back until confirm.
              state    <= WAIT_PRESS;
              LED_Wait <= 1'b1;
            end else begin
              Step_Enable <= 1'b1;
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end

        WAIT_PRESS: begin
          tick <= '0;
          if (!Esperar_Entrada) begin
            // Control unit withdrew the request: resume without a step.
            state    <= RUN;
            LED_Wait <= 1'b0;
          end else if (press) begin
            Entrada_valida <= data_sync;
            state          <= WAIT_RELEASE;
            LED_Wait       <= 1'b1;
          end else begin
            LED_Wait <= 1'b1;
          end
        end

        WAIT_RELEASE: begin
          tick <= '0;
          if (!btn_deb) begin
            // Step_Enable is raised together with the move into COMMIT,
            // so the pulse coincides with Estado == COMMIT.
            state       <= COMMIT;
            Step_Enable <= 1'b1;
            LED_Wait    <= 1'b0;
          end else begin
            LED_Wait <= 1'b1;
          end
        end

        COMMIT: begin
          state    <= RUN;
          tick     <= '0;
          LED_Wait <= 1'b0;
        end

        default: begin
          state    <= RUN;
          tick     <= '0;
          LED_Wait <= 1'b0;
        end
      endcase
    end
  end

  assign Estado = state;

endmodule

// File: tb/tb_entrada_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_entrada_step_ctrl
// Directed testbench for entrada_step_ctrl with DIV_COUNT=4,
// DEBOUNCE_CYCLES=3 and DATA_W=16. Inputs change and outputs are sampled
// 1 time unit after each rising edge. Expected values are derived by hand
// from the specified cycle timing.
// -----------------------------------------------------------------------------
module tb_entrada_step_ctrl;

  localparam int unsigned DW = 16;

  logic          clock;
  logic          reset_n;
  logic          esperar;
  logic          confirma;
  logic [DW-1:0] lida;
  logic          step;
  logic [DW-1:0] valida;
  logic          led_wait;
  logic [1:0]    estado;

  int unsigned   n_checks;
  int unsigned   n_errors;

  entrada_step_ctrl #(
    .DIV_COUNT       (4),
    .DEBOUNCE_CYCLES (3),
    .DATA_W          (DW)
  ) dut (
    .Clock            (clock),
    .Reset_n          (reset_n),
    .Esperar_Entrada  (esperar),
    .Confirma_Entrada (confirma),
    .Entrada_lida     (lida),
    .Step_Enable      (step),
    .Entrada_valida   (valida),
    .LED_Wait         (led_wait),
    .Estado           (estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    esperar  = 1'b0;
    confirma = 1'b0;
    lida     = '0;

    // Test 1: reset state, then a step on every 4th edge.
    cyc(2);
    check("rst_step",   32'(step),     32'd0);
    check("rst_valida", 32'(valida),   32'd0);
    check("rst_led",    32'(led_wait), 32'd0);
    check("rst_estado", 32'(estado),   32'd0);
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      check("t1_step",   32'(step),     (k % 4 == 0) ? 32'd1 : 32'd0);
      check("t1_led",    32'(led_wait), 32'd0);
      check("t1_estado", 32'(estado),   32'd0);
    end

    // Test 2: request input before a tick; the tick is swallowed.
    esperar = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      check("t2_step", 32'(step), 32'd0);
    end
    check("t2_estado", 32'(estado),   32'd1);
    check("t2_led",    32'(led_wait), 32'd1);
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      check("t2_hold_step",   32'(step),   32'd0);
      check("t2_hold_estado", 32'(estado), 32'd1);
    end

    // Test 3: clean press and release.
    lida     = 16'h00A5;
    confirma = 1'b1;
    cyc(5);
    check("t3_pre_estado", 32'(estado), 32'd1);
    check("t3_pre_valida", 32'(valida), 32'd0);
    cyc(1);
    check("t3_latch_estado", 32'(estado),   32'd2);
    check("t3_latch_valida", 32'(valida),   32'h00A5);
    check("t3_latch_led",    32'(led_wait), 32'd1);
    cyc(4);
    confirma = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      check("t3_rel_step",   32'(step),   32'd0);
      check("t3_rel_estado", 32'(estado), 32'd2);
    end
    cyc(1);
    check("t3_commit_step",   32'(step),     32'd1);
    check("t3_commit_estado", 32'(estado),   32'd3);
    check("t3_commit_led",    32'(led_wait), 32'd0);
    cyc(1);
    check("t3_after_step",   32'(step),     32'd0);
    check("t3_after_estado", 32'(estado),   32'd0);
    check("t3_after_led",    32'(led_wait), 32'd0);
    // Esperar is still high, so the next tick stalls again.
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      check("t3_run_step",   32'(step),   32'd0);
      check("t3_run_estado", 32'(estado), 32'd0);
    end
    cyc(1);
    check("t3_restall_step",   32'(step),   32'd0);
    check("t3_restall_estado", 32'(estado), 32'd1);

    // Test 4: a button that toggles every cycle never debounces.
    lida = 16'hBEEF;
    for (int k = 0; k < 12; k++) begin
      confirma = ~confirma;
      cyc(1);
      check("t4_bounce_step",   32'(step),   32'd0);
      check("t4_bounce_estado", 32'(estado), 32'd1);
    end
    confirma = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check("t4_idle_step",   32'(step),   32'd0);
      check("t4_idle_estado", 32'(estado), 32'd1);
    end
    check("t4_valida", 32'(valida), 32'h00A5);

    // Test 5: button already held when the stall begins.
    lida     = 16'h1234;
    esperar  = 1'b0;
    confirma = 1'b1;
    cyc(1);
    check("t5_resume_estado", 32'(estado), 32'd0);
    cyc(8);
    esperar = 1'b1;
    cyc(6);
    check("t5_stall_estado", 32'(estado), 32'd1);
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check("t5_held_estado", 32'(estado), 32'd1);
      check("t5_held_valida", 32'(valida), 32'h00A5);
      check("t5_held_step",   32'(step),   32'd0);
    end
    confirma = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check("t5_rel_estado", 32'(estado), 32'd1);
    end
    check("t5_rel_valida", 32'(valida), 32'h00A5);
    confirma = 1'b1;
    cyc(5);
    check("t5_pre_estado", 32'(estado), 32'd1);
    cyc(1);
    check("t5_latch_estado", 32'(estado), 32'd2);
    check("t5_latch_valida", 32'(valida), 32'h1234);
    cyc(4);
    check("t5_wr_estado", 32'(estado), 32'd2);

    // Test 6: reset while in WAIT_RELEASE discards the pending step.
    reset_n  = 1'b0;
    esperar  = 1'b0;
    confirma = 1'b0;
    cyc(1);
    check("t6_estado", 32'(estado),   32'd0);
    check("t6_valida", 32'(valida),   32'd0);
    check("t6_led",    32'(led_wait), 32'd0);
    check("t6_step",   32'(step),     32'd0);
    cyc(1);
    check("t6_rst2_step", 32'(step), 32'd0);
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      check("t6_run_step",   32'(step),   (k % 4 == 0) ? 32'd1 : 32'd0);
      check("t6_run_estado", 32'(estado), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
